// File: rtl/fifo_ctrl_4x8_pkg.sv
// rtl/fifo_ctrl_4x8_pkg.sv - shared sizes, word type and strobe encoding for the 4x8 FIFO controller
package fifo_ctrl_4x8_pkg;

    localparam int FIFO_MAIN_SIZE = 4;
    localparam int FIFO_ADDR_SIZE = 2;
    localparam int FIFO_DATA_SIZE = 8;

    typedef logic [FIFO_DATA_SIZE-1:0] fifo_word_t;

    // Accepted operation for one edge, packed as {write, read}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
        return fifo_op_e'({wr, rd});
    endfunction

endpackage

// File: rtl/fifo_ctrl_4x8_ptr_counter.sv
// rtl/fifo_ctrl_4x8_ptr_counter.sv - wrap-around address counter with enable
module fifo_ctrl_4x8_ptr_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Power-of-two depth: natural overflow is the mod-DEPTH wrap.
    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fifo_ctrl_4x8.sv
// rtl/fifo_ctrl_4x8.sv - pointer, occupancy and flag controller for a 4-entry x 8-bit FIFO memory
module fifo_ctrl_4x8
    import fifo_ctrl_4x8_pkg::*;
#(
    parameter int MAIN_SIZE = FIFO_MAIN_SIZE,
    parameter int ADDR_SIZE = FIFO_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR_SIZE:0]   thr_low,
    input  logic [ADDR_SIZE:0]   thr_high,
    output logic                 write,
    output logic                 read,
    output logic [MAIN_SIZE-1:0] wr_ptr,
    output logic [MAIN_SIZE-1:0] rd_ptr,
    output logic [ADDR_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic                 data_valid
);

    localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE + 1)'(1 << ADDR_SIZE);

    logic [ADDR_SIZE:0]   count_q;
    logic [ADDR_SIZE:0]   count_d;
    logic                 error_q;
    logic                 error_d;
    logic                 data_valid_q;
    logic                 data_valid_d;
    logic [ADDR_SIZE-1:0] wr_idx;
    logic [ADDR_SIZE-1:0] rd_idx;
    fifo_op_e             op;

    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= thr_high);
    assign almost_empty = !empty && (count_q <= thr_low);

    // Strobes use the pre-edge flags, so push&pop on full pops only and on empty pushes only.
    assign write = push & ~full & ~reset;
    assign read  = pop & ~empty & ~reset;
    assign op    = fifo_op(write, read);

    always_comb begin
        count_d = count_q;
        case (op)
            OP_PUSH: count_d = count_q + 1'b1;
            OP_POP:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        error_d      = error_q | (push & full & ~pop) | (pop & empty & ~push);
        data_valid_d = read;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            error_q      <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            error_q      <= error_d;
            data_valid_q <= data_valid_d;
        end
    end

    fifo_ctrl_4x8_ptr_counter #(.WIDTH(ADDR_SIZE)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (write),
        .value (wr_idx)
    );

    fifo_ctrl_4x8_ptr_counter #(.WIDTH(ADDR_SIZE)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .en    (read),
        .value (rd_idx)
    );

    // Memory address port is wider than the FIFO index; upper bits stay zero.
    assign wr_ptr     = MAIN_SIZE'(wr_idx);
    assign rd_ptr     = MAIN_SIZE'(rd_idx);
    assign count      = count_q;
    assign error      = error_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_fifo_ctrl_4x8.sv
// tb/tb_fifo_ctrl_4x8.sv - bench for fifo_ctrl_4x8 with a queue-based FIFO model and attached memory
module tb_fifo_ctrl_4x8;
    import fifo_ctrl_4x8_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [2:0] thr_low;
    logic [2:0] thr_high;
    logic       write;
    logic       read;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
    logic       data_valid;

    fifo_word_t din;
    fifo_word_t dout;
    fifo_word_t mem [0:15];

    int errors = 0;
    int checks = 0;

    fifo_word_t mq[$];
    int         m_count;
    int         m_wr;
    int         m_rd;
    logic       m_err;
    logic       m_dv;
    logic       m_w;
    logic       m_r;
    fifo_word_t m_word;

    fifo_ctrl_4x8 dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .thr_low      (thr_low),
        .thr_high     (thr_high),
        .write        (write),
        .read         (read),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .data_valid   (data_valid)
    );

    always #5 clk = ~clk;

    // The memory the controller drives, so data ordering is visible end to end.
    always @(posedge clk) begin
        if (write) mem[wr_ptr] <= din;
        if (read)  dout <= mem[rd_ptr];
    end

    task automatic model_reset();
        mq.delete();
        m_count = 0;
        m_wr    = 0;
        m_rd    = 0;
        m_err   = 1'b0;
        m_dv    = 1'b0;
    endtask

    task automatic set_in(input logic p, input logic q, input fifo_word_t d);
        @(negedge clk);
        push = p;
        pop  = q;
        din  = d;
        #1;
        m_w = p && (m_count < 4);
        m_r = q && (m_count > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if ((push && !pop && m_count == 4) || (pop && !push && m_count == 0)) m_err = 1'b1;
        if (m_w) begin
            mq.push_back(din);
            m_wr = (m_wr + 1) % 4;
        end
        if (m_r) begin
            m_word = mq.pop_front();
            m_rd   = (m_rd + 1) % 4;
        end
        m_count = m_count + (m_w ? 1 : 0) - (m_r ? 1 : 0);
        m_dv    = m_r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        thr_high = 3'd3;
        thr_low  = 3'd1;
        set_in(1'b1, 1'b0, 8'h11);
        tick();
        set_in(1'b1, 1'b0, 8'h22);
        tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pre_reset_count: got %0d expected 2", count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (wr_ptr !== 4'd0 || rd_ptr !== 4'd0) begin errors++; $display("FAIL reset_ptrs: got wr=%0d rd=%0d expected 0 0", wr_ptr, rd_ptr); end
        checks++; if (error !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL reset_err_dv: got err=%b dv=%b expected 0 0", error, data_valid); end
        checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin errors++; $display("FAIL reset_almost: got af=%b ae=%b expected 0 0", almost_full, almost_empty); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write_forced: got %b expected 0", write); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
    endtask

    task automatic test_fill();
        fifo_word_t words [4] = '{8'hA5, 8'hB6, 8'hC7, 8'hD8};
        int         exp_wr [4] = '{1, 2, 3, 0};
        thr_high = 3'd3;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, words[i]);
            checks++; if (write !== 1'b1) begin errors++; $display("FAIL fill_write[%0d]: got %b expected 1", i, write); end
            tick();
            checks++; if (wr_ptr !== 4'(exp_wr[i])) begin errors++; $display("FAIL fill_wr_ptr[%0d]: got %0d expected %0d", i, wr_ptr, exp_wr[i]); end
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 3)); end
            checks++; if (full !== (i + 1 == 4)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i + 1 == 4)); end
        end
    endtask

    task automatic test_overflow();
        set_in(1'b1, 1'b0, 8'hEE);
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL overflow_write: got %b expected 0", write); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL overflow_err_early: got %b expected 0", error); end
        tick();
        checks++; if (wr_ptr !== 4'd0) begin errors++; $display("FAIL overflow_wr_ptr: got %0d expected 0", wr_ptr); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count: got %0d expected 4", count); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL overflow_error: got %b expected 1", error); end
    endtask

    task automatic test_push_pop_full();
        set_in(1'b1, 1'b1, 8'h77);
        checks++; if (read !== 1'b1 || write !== 1'b0) begin errors++; $display("FAIL ppfull_strobes: got rd=%b wr=%b expected 1 0", read, write); end
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL ppfull_count: got %0d expected 3", count); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL ppfull_dv: got %b expected 1", data_valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL ppfull_data: got %h expected a5", dout); end
        checks++; if (rd_ptr !== 4'd1) begin errors++; $display("FAIL ppfull_rd_ptr: got %0d expected 1", rd_ptr); end
        set_in(1'b0, 1'b0, 8'h00);
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ppfull_dv_drop: got %b expected 0", data_valid); end
    endtask

    task automatic test_push_pop_mid();
        do_reset();
        set_in(1'b1, 1'b0, 8'h01);
        tick();
        set_in(1'b1, 1'b0, 8'h02);
        tick();
        set_in(1'b1, 1'b1, 8'h03);
        checks++; if (write !== 1'b1 || read !== 1'b1) begin errors++; $display("FAIL ppmid_strobes: got wr=%b rd=%b expected 1 1", write, read); end
        tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL ppmid_count: got %0d expected 2", count); end
        checks++; if (wr_ptr !== 4'd3 || rd_ptr !== 4'd1) begin errors++; $display("FAIL ppmid_ptrs: got wr=%0d rd=%0d expected 3 1", wr_ptr, rd_ptr); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ppmid_error: got %b expected 0", error); end
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL ppmid_data: got %h expected 01", dout); end
    endtask

    task automatic test_underflow();
        do_reset();
        thr_low = 3'd1;
        set_in(1'b0, 1'b1, 8'h00);
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL underflow_read: got %b expected 0", read); end
        tick();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL underflow_error: got %b expected 1", error); end
        checks++; if (count !== 3'd0 || rd_ptr !== 4'd0) begin errors++; $display("FAIL underflow_state: got cnt=%0d rd=%0d expected 0 0", count, rd_ptr); end
        set_in(1'b1, 1'b0, 8'h5A);
        tick();
        checks++; if (almost_empty !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL underflow_flags: got ae=%b empty=%b expected 1 0", almost_empty, empty); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL underflow_count: got %0d expected 1", count); end
    endtask

    task automatic test_thresholds();
        do_reset();
        thr_high = 3'd0;
        thr_low  = 3'd7;
        #1;
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL thr_af_zero: got %b expected 1", almost_full); end
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL thr_ae_empty: got %b expected 0", almost_empty); end
        set_in(1'b1, 1'b0, 8'h42);
        tick();
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL thr_ae_big: got %b expected 1", almost_empty); end
        thr_low  = 3'd0;
        thr_high = 3'd2;
        #1;
        checks++; if (almost_empty !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL thr_change: got ae=%b af=%b expected 0 0", almost_empty, almost_full); end
        thr_high = 3'd1;
        #1;
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL thr_af_eq: got %b expected 1", almost_full); end
    endtask

    task automatic test_random();
        logic p;
        logic q;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            thr_low  = 3'($urandom_range(0, 7));
            thr_high = 3'($urandom_range(0, 7));
            p = ($urandom_range(0, 99) < (i < 200 ? 65 : 35));
            q = ($urandom_range(0, 99) < (i < 200 ? 35 : 65));
            set_in(p, q, 8'($urandom));
            checks++; if (write !== m_w || read !== m_r) begin errors++; $display("FAIL rand_strobes[%0d]: got wr=%b rd=%b expected %b %b", i, write, read, m_w, m_r); end
            tick();
            checks++; if (count !== 3'(m_count)) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, m_count); end
            checks++; if (wr_ptr !== 4'(m_wr) || rd_ptr !== 4'(m_rd)) begin errors++; $display("FAIL rand_ptrs[%0d]: got wr=%0d rd=%0d expected %0d %0d", i, wr_ptr, rd_ptr, m_wr, m_rd); end
            checks++; if (full !== (m_count == 4) || empty !== (m_count == 0)) begin errors++; $display("FAIL rand_full_empty[%0d]: got f=%b e=%b count_model=%0d", i, full, empty, m_count); end
            checks++; if (almost_full !== (m_count >= int'(thr_high))) begin errors++; $display("FAIL rand_af[%0d]: got %b expected %b", i, almost_full, (m_count >= int'(thr_high))); end
            checks++; if (almost_empty !== (m_count != 0 && m_count <= int'(thr_low))) begin errors++; $display("FAIL rand_ae[%0d]: got %b expected %b", i, almost_empty, (m_count != 0 && m_count <= int'(thr_low))); end
            checks++; if (error !== m_err || data_valid !== m_dv) begin errors++; $display("FAIL rand_err_dv[%0d]: got err=%b dv=%b expected %b %b", i, error, data_valid, m_err, m_dv); end
            if (m_dv) begin
                checks++; if (dout !== m_word) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, dout, m_word); end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        din      = '0;
        thr_low  = 3'd1;
        thr_high = 3'd3;
        model_reset();
        #12;
        reset = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_push_pop_full();
        test_push_pop_mid();
        test_underflow();
        test_thresholds();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
